// File: rtl/user_id_pkg.sv
// user_id_capture shared definitions: register offsets,
// STATUS field positions, FSM states and serial length.
package user_id_pkg;

  localparam logic [3:0] ID_OFS     = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] CTRL_OFS   = 4'h8;

  localparam int STATUS_VALID     = 0;
  localparam int STATUS_SAMPLING  = 1;
  localparam int STATUS_RECAP_LSB = 8;

  localparam int SER_LEN = 32;

  typedef enum logic {
    SAMPLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/user_id_shifter.sv
// MSB-first serial dump of a loaded ID word.
// Busy for exactly SER_LEN cycles after the load edge.
module user_id_shifter
  import user_id_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [SER_LEN-1:0] data,
  output logic               dat,
  output logic               busy
);

  logic [SER_LEN-1:0] sh;
  logic [5:0]         left;

  // load a fresh copy, then shift left once per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh   <= '0;
      left <= '0;
    end else if (load) begin
      sh   <= data;
      left <= 6'(SER_LEN);
    end else if (left != 6'd0) begin
      sh   <= {sh[SER_LEN-2:0], 1'b0};
      left <= left - 6'd1;
    end
  end

  assign busy = (left != 6'd0);
  assign dat  = busy & sh[SER_LEN-1];

endmodule

// File: rtl/user_id_capture.sv
// Qualifies the mask-programmed user ID and publishes it over Wishbone.
// Optional serial dump port enabled by USER_ID_SERIAL_EN.
module user_id_capture
  import user_id_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_F000,
  parameter int          STABLE_CYCLES = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] mask_rev_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] id_o,
  output logic        id_valid_o,
  input  logic        ser_start_i,
  output logic        ser_dat_o,
  output logic        ser_busy_o
);

  state_t      state, state_n;
  logic [31:0] smp;
  logic [7:0]  cnt;
  logic [7:0]  recap_cnt;
  logic [31:0] id;
  logic        valid;
  logic [31:0] rdata;
  logic [3:0]  ofs;
  logic        hit, access, recap, match, lock_hit;

  assign hit    = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign access = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
  assign ofs    = {wbs_adr_i[3:2], 2'b00};
  assign recap  = access & wbs_we_i & (ofs == CTRL_OFS) & wbs_dat_i[0];

  assign match    = (mask_rev_i == smp);
  assign lock_hit = (state == SAMPLE) & match
                  & (cnt == 8'(STABLE_CYCLES - 1));

  // FSM state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= SAMPLE;
    else          state <= state_n;
  end

  // next state: recapture beats a coincident lock
  always_comb begin
    state_n = state;
    if (recap)         state_n = SAMPLE;
    else if (lock_hit) state_n = LOCKED;
  end

  // sample/compare counter, locked ID and recapture count
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      smp       <= '0;
      cnt       <= '0;
      recap_cnt <= '0;
      id        <= '0;
      valid     <= 1'b0;
    end else if (recap) begin
      cnt       <= '0;
      valid     <= 1'b0;
      recap_cnt <= recap_cnt + 8'd1;
    end else if (state == SAMPLE) begin
      if (!match) begin
        smp <= mask_rev_i;
        cnt <= '0;
      end else if (lock_hit) begin
        id    <= smp;
        valid <= 1'b1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign id_o       = id;
  assign id_valid_o = valid;

  // read mux; unmapped and write-only offsets read as 0
  always_comb begin
    rdata = '0;
    unique case (ofs)
      ID_OFS: rdata = id;
      STATUS_OFS: begin
        rdata[STATUS_VALID]    = valid;
        rdata[STATUS_SAMPLING] = (state == SAMPLE);
        rdata[STATUS_RECAP_LSB +: 8] = recap_cnt;
      end
      default: rdata = '0;
    endcase
  end

  // single-cycle registered ack; data only alongside a read ack
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access & ~wbs_we_i) ? rdata : 32'h0;
    end
  end

`ifdef USER_ID_SERIAL_EN
  logic ser_load;
  logic unused;

  assign ser_load = ser_start_i & valid & ~ser_busy_o;

  user_id_shifter u_shifter (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .load (ser_load),
    .data (id),
    .dat  (ser_dat_o),
    .busy (ser_busy_o)
  );

  assign unused = &{1'b0, wbs_sel_i, wbs_adr_i[1:0],
                    wbs_dat_i[31:1]};
`else
  logic unused;

  assign ser_dat_o  = 1'b0;
  assign ser_busy_o = 1'b0;
  assign unused = &{1'b0, wbs_sel_i, wbs_adr_i[1:0],
                    wbs_dat_i[31:1], ser_start_i};
`endif

endmodule
